// File: rtl/os_array_ctrl.sv
// Sequencing controller for an output-stationary PE array: clear, feed k_len skewed
// beats, flush the skew, drain one accumulator row per handshake, then signal done.
module os_array_ctrl #(
   parameter int ROWS  = 4,
   parameter int COLS  = 4,
   parameter int KW    = 8,
   parameter int STAGE = 0,
   localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [KW-1:0] k_len,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          pipeline_en,
   output logic          cell_en,
   output logic          reg_clear,
   output logic          drain_valid,
   input  logic          drain_ready,
   output logic [RW-1:0] drain_row,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [2:0]    dbg_state
);

   // Handshakes: a beat moves when in_valid & in_ready, a row moves when
   // drain_valid & drain_ready; a valid side holds its data until the transfer.
   localparam int F      = ROWS + COLS - 2 + STAGE;
   localparam int FW     = (F > 1) ? $clog2(F) : 1;
   localparam int F_LAST_I = (F > 0) ? F - 1 : 0;
   localparam logic [FW-1:0] F_LAST   = FW'(F_LAST_I);
   localparam logic [FW-1:0] F_ONE    = FW'(1);
   localparam logic [KW-1:0] K_ONE    = KW'(1);
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
   localparam logic [RW-1:0] ROW_ONE  = RW'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_FEED  = 3'd2,
      S_FLUSH = 3'd3,
      S_DRAIN = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [KW-1:0] r_k_len;
   logic [KW-1:0] r_k_cnt;
   logic [FW-1:0] r_f_cnt;
   logic [RW-1:0] r_drain_row;
   logic          r_err;
   logic          w_beat;
   logic          w_drain_hs;
   logic          w_start_ok;

   assign w_start_ok = start && (k_len != '0);
   assign w_beat     = (r_state == S_FEED) && in_valid;
   assign w_drain_hs = (r_state == S_DRAIN) && drain_ready;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      in_ready    = 1'b0;
      pipeline_en = 1'b0;
      cell_en     = 1'b0;
      reg_clear   = 1'b0;
      drain_valid = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start_ok) w_next = S_CLEAR;
         end
         S_CLEAR: begin
            reg_clear = 1'b1;
            w_next    = S_FEED;
         end
         S_FEED: begin
            // The array only advances on an accepted beat, so skew stays aligned.
            in_ready    = 1'b1;
            pipeline_en = w_beat;
            cell_en     = w_beat;
            if (w_beat && (r_k_cnt == r_k_len - K_ONE)) w_next = S_FLUSH;
         end
         S_FLUSH: begin
            pipeline_en = 1'b1;
            if (r_f_cnt == F_LAST) w_next = S_DRAIN;
         end
         S_DRAIN: begin
            drain_valid = 1'b1;
            if (w_drain_hs && (r_drain_row == ROW_LAST)) w_next = S_DONE;
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_k_len     <= '0;
         r_k_cnt     <= '0;
         r_f_cnt     <= '0;
         r_drain_row <= '0;
         r_err       <= 1'b0;
      end else begin
         r_err <= (r_state == S_IDLE) && start && (k_len == '0);
         case (r_state)
            S_IDLE: begin
               if (w_start_ok) r_k_len <= k_len;
            end
            S_CLEAR: begin
               r_k_cnt     <= '0;
               r_f_cnt     <= '0;
               r_drain_row <= '0;
            end
            S_FEED: begin
               if (w_beat) r_k_cnt <= r_k_cnt + K_ONE;
            end
            S_FLUSH: begin
               if (r_f_cnt != F_LAST) r_f_cnt <= r_f_cnt + F_ONE;
            end
            S_DRAIN: begin
               // Row index parks on the last row rather than wrapping.
               if (w_drain_hs && (r_drain_row != ROW_LAST))
                  r_drain_row <= r_drain_row + ROW_ONE;
            end
            default: ;
         endcase
      end
   end

   assign drain_row = r_drain_row;
   assign busy      = (r_state != S_IDLE);
   assign err       = r_err;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_os_array_ctrl.sv
// Directed bench for os_array_ctrl (ROWS=COLS=4, STAGE=0, KW=8): drained row indices
// are queued when a tile starts and popped as each drain handshake is observed.
module tb_os_array_ctrl;

   localparam int FLUSH_N = 6;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FLUSH = 3'd3;
   localparam logic [2:0] ST_DRAIN = 3'd4;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] k_len;
   logic       in_valid;
   logic       in_ready;
   logic       pipeline_en;
   logic       cell_en;
   logic       reg_clear;
   logic       drain_valid;
   logic       drain_ready;
   logic [1:0] drain_row;
   logic       busy;
   logic       done;
   logic       err;
   logic [2:0] dbg_state;

   logic [1:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   os_array_ctrl #(.ROWS(4), .COLS(4), .KW(8), .STAGE(0)) dut (
      .clk(clk), .rst(rst), .start(start), .k_len(k_len),
      .in_valid(in_valid), .in_ready(in_ready), .pipeline_en(pipeline_en),
      .cell_en(cell_en), .reg_clear(reg_clear), .drain_valid(drain_valid),
      .drain_ready(drain_ready), .drain_row(drain_row), .busy(busy),
      .done(done), .err(err), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every drain handshake must present the next queued row index.
   always @(negedge clk) begin
      logic [31:0] exp_v;
      if (!rst && drain_valid && drain_ready) begin
         exp_v = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'd99;
         check("drain_row", 32'(drain_row), exp_v);
      end
   end

   task automatic check_idle_outputs(input string tag);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_pipeline_en"}, pipeline_en, 0);
      check({tag, "_cell_en"}, cell_en, 0);
      check({tag, "_reg_clear"}, reg_clear, 0);
      check({tag, "_drain_valid"}, drain_valid, 0);
      check({tag, "_drain_row"}, drain_row, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_state"}, dbg_state, ST_IDLE);
   endtask

   task automatic run_tile(input int k, input bit toggle, input bit poke, input int exp_lat);
      int beats = 0;
      int clears = 0;
      int flush = 0;
      int errs = 0;
      int lat = 0;
      bit seen = 0;
      bit poked = 0;
      for (int r = 0; r < 4; r++) exp_q.push_back(r[1:0]);
      in_valid = 1'b1;
      drain_ready = 1'b1;
      start = 1'b1;
      k_len = k[7:0];
      tick();
      start = 1'b0;
      for (int c = 1; c <= 2000; c++) begin
         @(negedge clk);
         lat = c;
         if (in_ready) begin
            check("feed_pipeline_en", pipeline_en, in_valid);
            check("feed_cell_en", cell_en, in_valid);
         end
         beats  += int'(cell_en);
         clears += int'(reg_clear);
         flush  += int'(pipeline_en && !in_ready);
         errs   += int'(err);
         if (done) begin
            seen = 1'b1;
            break;
         end
         tick();
         start = 1'b0;
         if (poke && !poked && in_ready) begin
            start = 1'b1;
            k_len = 8'd200;
            poked = 1'b1;
         end
         if (toggle) in_valid = ~in_valid;
      end
      start = 1'b0;
      check("tile_done_seen", seen, 1);
      check("tile_beats", beats, k);
      check("tile_clear_cycles", clears, 1);
      check("tile_flush_cycles", flush, FLUSH_N);
      check("tile_err_quiet", errs, 0);
      check("tile_rows_drained", exp_q.size(), 0);
      if (exp_lat > 0) check("tile_done_latency", lat, exp_lat);
      tick();
      @(negedge clk);
      check("post_tile_busy", busy, 0);
      check("post_tile_done", done, 0);
      check("post_tile_state", dbg_state, ST_IDLE);
   endtask

   initial begin
      int w;
      rst = 1'b1;
      start = 1'b0;
      k_len = '0;
      in_valid = 1'b0;
      drain_ready = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check_idle_outputs("reset");
      tick();
      rst = 1'b0;

      // Basic tile: CLEAR + 3 beats + 6 flush + 4 rows + DONE.
      run_tile(3, 1'b0, 1'b0, 15);

      // Alternating in_valid: array must stall on every idle feed cycle.
      run_tile(4, 1'b1, 1'b0, 0);

      // Zero-length start flags err and never leaves IDLE.
      start = 1'b1;
      k_len = 8'd0;
      tick();
      start = 1'b0;
      @(negedge clk);
      check("zero_len_err", err, 1);
      check("zero_len_busy", busy, 0);
      check("zero_len_reg_clear", reg_clear, 0);
      check("zero_len_state", dbg_state, ST_IDLE);
      tick();
      @(negedge clk);
      check("zero_len_err_pulse", err, 0);

      // Start re-issued during FEED is ignored.
      run_tile(2, 1'b0, 1'b1, 14);

      // Drain backpressure at row 2.
      for (int r = 0; r < 4; r++) exp_q.push_back(r[1:0]);
      in_valid = 1'b1;
      drain_ready = 1'b0;
      start = 1'b1;
      k_len = 8'd1;
      tick();
      start = 1'b0;
      w = 0;
      @(negedge clk);
      while (!drain_valid && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("stall_reach_drain", drain_valid, 1);
      check("stall_first_row", drain_row, 0);
      tick();
      drain_ready = 1'b1;
      @(negedge clk);
      tick();
      @(negedge clk);
      tick();
      drain_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_valid_held", drain_valid, 1);
         check("stall_row_held", drain_row, 2);
         check("stall_state_held", dbg_state, ST_DRAIN);
         tick();
      end
      drain_ready = 1'b1;
      @(negedge clk);
      tick();
      @(negedge clk);
      tick();
      @(negedge clk);
      check("stall_done", done, 1);
      check("stall_rows_drained", exp_q.size(), 0);
      tick();

      // Reset in the second FLUSH cycle aborts the tile.
      in_valid = 1'b1;
      drain_ready = 1'b1;
      start = 1'b1;
      k_len = 8'd1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      @(negedge clk);
      check("abort_in_flush", dbg_state, ST_FLUSH);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("abort");
      run_tile(1, 1'b0, 1'b0, 13);

      // Longest reduction length.
      run_tile(255, 1'b0, 1'b0, 267);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
